// File: rtl/siaminer_pkg.sv
// siaminer_pkg
//   Shared constants and helpers for the siaminer hashing core.
//   - B2B_* : BLAKE2b word width and G rotation amounts
//   - B2S_* : BLAKE2s word width and G rotation amounts
//   - ror() : rotate-right of the low 'width' bits of a 64-bit container
package siaminer_pkg;

  localparam int B2B_W  = 64;
  localparam int B2B_R1 = 32;
  localparam int B2B_R2 = 24;
  localparam int B2B_R3 = 16;
  localparam int B2B_R4 = 63;

  localparam int B2S_W  = 32;
  localparam int B2S_R1 = 16;
  localparam int B2S_R2 = 12;
  localparam int B2S_R3 = 8;
  localparam int B2S_R4 = 7;

  // Words up to 64 bits travel in a 64-bit container; bits above 'width'
  // are ignored on input and returned as zero.
  function automatic logic [63:0] ror(input logic [63:0] value,
                                      input int unsigned amount,
                                      input int unsigned width = 64);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    v    = value & mask;
    return ((v >> amount) | (v << (width - amount))) & mask;
  endfunction

endpackage

// File: rtl/mix_pipe_mix_half.sv
// mix_half
//   Combinational half of the BLAKE2 G function:
//     a += b + m; d = ror(d ^ a, RA); c += d; b = ror(b ^ c, RB)
//   Ports:
//     a, b, c, d, m               in   W  working words and message word
//     a_mix, b_mix, c_mix, d_mix  out  W  mixed words
module mix_half
  import siaminer_pkg::*;
#(
  parameter int W  = B2B_W,
  parameter int RA = B2B_R1,
  parameter int RB = B2B_R2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] m,
  output logic [W-1:0] a_mix,
  output logic [W-1:0] b_mix,
  output logic [W-1:0] c_mix,
  output logic [W-1:0] d_mix
);

  always_comb begin
    a_mix = a + b + m;
    d_mix = W'(ror(64'(d ^ a_mix), RA, W));
    c_mix = c + d_mix;
    b_mix = W'(ror(64'(b ^ c_mix), RB, W));
  end

endmodule

// File: rtl/mix_pipe.sv
// mix_pipe
//   Pipelined BLAKE2 G mixing function with valid/ready handshake and a tag
//   sideband. PIPE=2 registers the state after the first half-G (latency 2),
//   PIPE=1 computes the full G into the output register (latency 1).
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     in_valid/in_ready            input handshake
//     in_tag                       opaque id returned with the result
//     a_in, b_in, c_in, d_in       working words Va..Vd
//     x_in, y_in                   message words for the two half-G steps
//     out_valid/out_ready          output handshake
//     out_tag                      tag of the presented result
//     a_out, b_out, c_out, d_out   mixed working words
module mix_pipe
  import siaminer_pkg::*;
#(
  parameter int W     = B2B_W,
  parameter int R1    = B2B_R1,
  parameter int R2    = B2B_R2,
  parameter int R3    = B2B_R3,
  parameter int R4    = B2B_R4,
  parameter int PIPE  = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic [W-1:0]     c_in,
  input  logic [W-1:0]     d_in,
  input  logic [W-1:0]     x_in,
  input  logic [W-1:0]     y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic [W-1:0]     c_out,
  output logic [W-1:0]     d_out
);

  // Parameter legality, caught at elaboration.
  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("mix_pipe: PIPE must be 1 or 2");
  end
  if (W < 2 || W > 64) begin : g_bad_w
    $error("mix_pipe: W must be in 2..64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("mix_pipe: TAG_W must be >= 1");
  end
  if (R1 < 1 || R1 > W-1 || R2 < 1 || R2 > W-1 ||
      R3 < 1 || R3 > W-1 || R4 < 1 || R4 > W-1) begin : g_bad_rot
    $error("mix_pipe: rotation amounts must be in 1..W-1");
  end

  // First half-G, always driven straight from the input operands.
  logic [W-1:0] h1_a, h1_b, h1_c, h1_d;

  mix_half #(.W(W), .RA(R1), .RB(R2)) u_half1 (
    .a     (a_in),
    .b     (b_in),
    .c     (c_in),
    .d     (d_in),
    .m     (x_in),
    .a_mix (h1_a),
    .b_mix (h1_b),
    .c_mix (h1_c),
    .d_mix (h1_d)
  );

  // Operands feeding the second half-G: either the stage-1 register or the
  // first half-G output directly.
  logic [W-1:0]     s_a, s_b, s_c, s_d, s_y;
  logic [TAG_W-1:0] s_tag;
  logic             s_valid;
  logic             en_out;

  // Output stage accepts when empty or when its current result leaves.
  assign en_out = ~out_valid | out_ready;

  if (PIPE == 2) begin : g_pipe2
    logic [W-1:0]     st_a_reg, st_b_reg, st_c_reg, st_d_reg, st_y_reg;
    logic [TAG_W-1:0] st_tag_reg;
    logic             st_valid_reg;
    logic             en_st;

    assign en_st    = ~st_valid_reg | en_out;
    assign in_ready = en_st & ~rst;

    always_ff @(posedge clk) begin
      if (rst) begin
        st_valid_reg <= 1'b0;
      end else if (en_st) begin
        st_valid_reg <= in_valid;
      end
    end

    // Data only, no reset: contents are meaningless while st_valid_reg=0.
    always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
        st_a_reg   <= h1_a;
        st_b_reg   <= h1_b;
        st_c_reg   <= h1_c;
        st_d_reg   <= h1_d;
        st_y_reg   <= y_in;
        st_tag_reg <= in_tag;
      end
    end

    assign s_a     = st_a_reg;
    assign s_b     = st_b_reg;
    assign s_c     = st_c_reg;
    assign s_d     = st_d_reg;
    assign s_y     = st_y_reg;
    assign s_tag   = st_tag_reg;
    assign s_valid = st_valid_reg;
  end else begin : g_pipe1
    assign in_ready = en_out & ~rst;
    assign s_a      = h1_a;
    assign s_b      = h1_b;
    assign s_c      = h1_c;
    assign s_d      = h1_d;
    assign s_y      = y_in;
    assign s_tag    = in_tag;
    assign s_valid  = in_valid;
  end

  logic [W-1:0] f_a, f_b, f_c, f_d;

  mix_half #(.W(W), .RA(R3), .RB(R4)) u_half2 (
    .a     (s_a),
    .b     (s_b),
    .c     (s_c),
    .d     (s_d),
    .m     (s_y),
    .a_mix (f_a),
    .b_mix (f_b),
    .c_mix (f_c),
    .d_mix (f_d)
  );

  // Output register. Holds everything while stalled (en_out=0), so the
  // presented result stays stable until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      d_out     <= '0;
    end else if (en_out) begin
      out_valid <= s_valid;
      if (s_valid) begin
        out_tag <= s_tag;
        a_out   <= f_a;
        b_out   <= f_b;
        c_out   <= f_c;
        d_out   <= f_d;
      end
    end
  end

endmodule
